apb_mem_slave: RTL
==================

Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave; next generation of the team's fixed 16x8 APB register-memory slave. Adds configurable address/data width and depth, byte strobes (PSTRB), programmable wait states, and real PSLVERR generation for bad addresses. Sits behind the APB bridge as a scratch/config memory target.

Parameters:
ADDR_WIDTH, 16, PADDR width in bits (byte address)
DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64
DEPTH, 64, number of DATA_WIDTH words; legal range 2..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))
WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15)
CLEAR_ON_RESET, 1, when 1 all memory words are cleared to 0 by reset

Ports:
PCLK  in  1  APB clock; all state updates on rising edge
PRESET  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte enables; ignored on reads
PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0
PREADY  out  1  transfer completes in this cycle
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset: PRESET is asynchronous, active-low; clock is PCLK. On PRESET=0: state=IDLE, wait counter=0, PRDATA=0, err flag=0, so PREADY=0 and PSLVERR=0; memory cleared to 0 if CLEAR_ON_RESET=1, else contents retained. Reset mid-transfer aborts it; no memory write occurs.
- Word index = PADDR >> log2(DATA_WIDTH/8). Error conditions, evaluated in setup: index >= DEPTH, or PADDR low log2(DATA_WIDTH/8) bits nonzero (misaligned).
- States: IDLE, ACCESS.
- IDLE: PREADY=0. Setup (PSEL=1, PENABLE=0) -> ACCESS. On that edge: counter <= WAIT_STATES; err <= error condition; PRDATA <= (read && !error) ? mem[index] : 0. PSEL=1 with PENABLE=1 in IDLE is a protocol violation: ignore and stay in IDLE.
- ACCESS: PREADY = (counter==0), combinational from registered state. PSLVERR = PREADY & err.
  - PSEL=1, PENABLE=1, counter>0: counter decrements.
  - PSEL=1, PENABLE=1, counter==0: completion edge. A write with err=0 updates mem[index] per byte where PSTRB[b]=1; an error write leaves memory unchanged. -> IDLE.
  - PSEL=0 or PENABLE=0 before completion (master abort): -> IDLE, no write, PRDATA unchanged.
- Latency: an access phase lasts WAIT_STATES+1 cycles. Zero-wait gives the standard 2-cycle APB transfer.
- Back-to-back: a new setup may begin the cycle after completion; IDLE handles it with no extra idle cycle.
- Address/data/strobe are sampled from the bus: in setup for index/err, and at the completion edge for PWDATA/PSTRB. The master holds them stable per APB rules; the slave does not re-check them.
- PSTRB=0 on a write is a legal no-op and completes with PSLVERR=0.
- PRDATA holds its last value outside read completions; it is not required to be zero.

Decomposition:
- Package apb_pkg: state encoding (IDLE, ACCESS), APB_OKAY/APB_ERROR response constants, and a function computing the word-index shift from DATA_WIDTH.
- Sub-module apb_mem_array: DEPTH x DATA_WIDTH storage with per-byte write enable, synchronous write, combinational read port, and optional reset clear. Keeps the FSM synthesizable against an SRAM swap later.

Test Plan:
1. Defaults. Write 0xDEADBEEF to 0x0008 with PSTRB=0xF, then read 0x0008 -> PREADY=1 in the first access cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
2. Byte strobes. Prefill 0x11223344 at 0x0010; write 0xAABBCCDD with PSTRB=0x5 -> readback 0x11BB33DD.
3. WAIT_STATES=3. Read -> PREADY low for exactly 3 access cycles, high on the 4th; the transfer spans 5 cycles including setup.
4. Errors. Write to 0x0100 (index 64 = DEPTH) and to 0x0002 (misaligned) -> PSLVERR=1 with PREADY; memory unchanged. A read of 0x0100 returns PRDATA=0 with PSLVERR=1.
5. Abort and reset. WAIT_STATES=2: drop PENABLE mid-wait -> state back to IDLE, no write. Assert PRESET during ACCESS -> PREADY=0 and PSLVERR=0 immediately (asynchronous). With CLEAR_ON_RESET=1, a subsequent read of 0x0008 returns 0.
6. Back-to-back. Write then read with no idle cycle between transfers -> each completes in 2 cycles, and the read returns the just-written data.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave.
//   apb_state_e : FSM state encoding (IDLE, ACCESS)
//   APB_OKAY / APB_ERROR : PSLVERR response values
//   idx_shift() : byte-address to word-index shift for a given data width
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_OKAY  = 1'b0;
  localparam logic APB_ERROR = 1'b1;

  // Number of low PADDR bits that select a byte within one data word.
  function automatic int idx_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a master and the memory slave.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB : master -> slave
//   PRDATA, PREADY, PSLVERR                     : slave -> master
// Clock and reset are not part of the bundle; they stay plain ports.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH word storage with per-byte write enables.
//   clk_i    : write clock (rising edge)
//   rst_ni   : asynchronous active-low reset; clears storage when CLEAR_ON_RESET=1
//   we_i     : write enable
//   be_i     : byte enables for the write
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index (combinational read)
//   rdata_o  : read data; zero for indices at or beyond DEPTH
// Kept separate from the bus FSM so the flop array can be swapped for an SRAM macro.
module apb_mem_array #(
  parameter int DEPTH          = 64,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int IDX_W          = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Index width may cover more than DEPTH words when DEPTH is not a power of two.
  assign rdata_o = ({1'b0, raddr_i} < (IDX_W+1)'(DEPTH)) ? mem_q[raddr_i] : '0;

  if (CLEAR_ON_RESET) begin : g_clr
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (we_i) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end else begin : g_keep
    always_ff @(posedge clk_i) begin
      if (we_i) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 memory-mapped slave with byte strobes, programmable
// wait states and PSLVERR on out-of-range or misaligned addresses.
//   PCLK   : APB clock, all state updates on the rising edge
//   PRESET : asynchronous active-low reset
//   bus    : APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in,
//            PRDATA/PREADY/PSLVERR out)
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 64,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_mem_slave_if.slave bus
);

  localparam int SHIFT  = idx_shift(DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH+1)'(DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [ADDR_WIDTH-1:0] full_idx;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Setup-phase address decode.
  assign full_idx  = bus.PADDR >> SHIFT;
  assign setup_idx = full_idx[IDX_W-1:0];
  assign setup_err = ({1'b0, full_idx} >= DEPTH_W) || ((bus.PADDR & ALIGN_MASK) != '0);

  apb_mem_array #(
    .DEPTH          (DEPTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .IDX_W          (IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_ni  (PRESET),
    .we_i    (mem_we),
    .be_i    (bus.PSTRB[NBYTES-1:0]),
    .waddr_i (idx_q),
    .wdata_i (bus.PWDATA),
    .raddr_i (setup_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    idx_d    = idx_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high here is a protocol violation; ignore it.
        if (bus.PSEL && !bus.PENABLE) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_STATES);
          err_d    = setup_err ? APB_ERROR : APB_OKAY;
          prdata_d = (!bus.PWRITE && !setup_err) ? mem_rdata : '0;
          idx_d    = setup_idx;
        end
      end
      ACCESS: begin
        if (bus.PSEL && bus.PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            mem_we  = bus.PWRITE && (err_q == APB_OKAY);
            state_d = IDLE;
          end
        end else begin
          // Master abort: leave without writing, PRDATA untouched.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      err_q    <= APB_OKAY;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // Word index is only consumed while err_q is clear, so it needs no reset.
  always_ff @(posedge PCLK) begin
    idx_q <= idx_d;
  end

  assign bus.PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign bus.PSLVERR = bus.PREADY && err_q;
  assign bus.PRDATA  = prdata_q;

endmodule
